// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master SDRAM Wishbone arbiter.
package wshb_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int HOLD_W = 8;
endpackage

// File: rtl/wshb_arb_pick.sv
// Combinational winner select for a new grant out of IDLE.
module wshb_arb_pick
    import wshb_arb_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       win
);

    always_comb begin
        valid = |req;
        win   = req[1];
        // On a tie, round-robin favours whoever did not own the bus last.
        if (req == 2'b11)
            win = (PRIO_MODE == 1) ? 1'b0 : ~last;
    end

endmodule

// File: rtl/wshb_arbiter.sv
// Shares the SDRAM Wishbone slave port between the VGA reader (s0) and the
// stream writer (s1); one owner per Wishbone cycle, cooperative release.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int PRIO_MODE = 0,
    parameter int MAX_HOLD  = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        s0_cyc,
    input  logic        s0_stb,
    input  logic        s0_we,
    input  logic [31:0] s0_adr,
    input  logic [3:0]  s0_sel,
    input  logic [31:0] s0_dat_ms,
    input  logic [2:0]  s0_cti,
    input  logic [1:0]  s0_bte,
    output logic        s0_ack,
    output logic        s0_err,
    output logic        s0_rty,
    output logic [31:0] s0_dat_sm,
    input  logic        s1_cyc,
    input  logic        s1_stb,
    input  logic        s1_we,
    input  logic [31:0] s1_adr,
    input  logic [3:0]  s1_sel,
    input  logic [31:0] s1_dat_ms,
    input  logic [2:0]  s1_cti,
    input  logic [1:0]  s1_bte,
    output logic        s1_ack,
    output logic        s1_err,
    output logic        s1_rty,
    output logic [31:0] s1_dat_sm,
    output logic        m_cyc,
    output logic        m_stb,
    output logic        m_we,
    output logic [31:0] m_adr,
    output logic [3:0]  m_sel,
    output logic [31:0] m_dat_ms,
    output logic [2:0]  m_cti,
    output logic [1:0]  m_bte,
    input  logic        m_ack,
    input  logic        m_err,
    input  logic        m_rty,
    input  logic [31:0] m_dat_sm,
    output logic [1:0]  grant,
    output logic        force_rel
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    arb_state_t          state;
    logic                last;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                fired;
    logic                pick_valid;
    logic                pick_win;
    logic                owner_cyc;
    logic                other_cyc;

    wshb_arb_pick #(.PRIO_MODE(PRIO_MODE)) u_pick (
        .req   ({s1_cyc, s0_cyc}),
        .last  (last),
        .valid (pick_valid),
        .win   (pick_win)
    );

    assign owner_cyc = (state == OWN1) ? s1_cyc : s0_cyc;
    assign other_cyc = (state == OWN1) ? s0_cyc : s1_cyc;
    assign grant     = {state == OWN1, state == OWN0};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            hold_cnt  <= '0;
            fired     <= 1'b0;
            force_rel <= 1'b0;
        end else begin
            force_rel <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= pick_win ? OWN1 : OWN0;
                        hold_cnt <= '0;
                        fired    <= 1'b0;
                    end
                end
                OWN0, OWN1: begin
                    if (!owner_cyc) begin
                        state <= IDLE;
                        last  <= (state == OWN1);
                    end else begin
                        if (m_ack && hold_cnt != '1)
                            hold_cnt <= hold_cnt + 1'b1;
                        // Advisory only: the owner keeps the bus until it drops cyc.
                        if (MAX_HOLD != 0 && hold_cnt == MAX_HOLD_C && other_cyc && !fired) begin
                            force_rel <= 1'b1;
                            fired     <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_cyc     = 1'b0;
        m_stb     = 1'b0;
        m_we      = 1'b0;
        m_adr     = '0;
        m_sel     = '0;
        m_dat_ms  = '0;
        m_cti     = '0;
        m_bte     = '0;
        s0_ack    = 1'b0;
        s0_err    = 1'b0;
        s0_rty    = 1'b0;
        s0_dat_sm = '0;
        s1_ack    = 1'b0;
        s1_err    = 1'b0;
        s1_rty    = 1'b0;
        s1_dat_sm = '0;
        case (state)
            OWN0: begin
                m_cyc     = s0_cyc;
                m_stb     = s0_stb;
                m_we      = s0_we;
                m_adr     = s0_adr;
                m_sel     = s0_sel;
                m_dat_ms  = s0_dat_ms;
                m_cti     = s0_cti;
                m_bte     = s0_bte;
                s0_ack    = m_ack;
                s0_err    = m_err;
                s0_rty    = m_rty;
                s0_dat_sm = m_dat_sm;
            end
            OWN1: begin
                m_cyc     = s1_cyc;
                m_stb     = s1_stb;
                m_we      = s1_we;
                m_adr     = s1_adr;
                m_sel     = s1_sel;
                m_dat_ms  = s1_dat_ms;
                m_cti     = s1_cti;
                m_bte     = s1_bte;
                s1_ack    = m_ack;
                s1_err    = m_err;
                s1_rty    = m_rty;
                s1_dat_sm = m_dat_sm;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench: round-robin/MAX_HOLD=4 instance (a_) and fixed-priority/unlimited instance (b_).
module tb_wshb_arbiter;
    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_inj = 1'b0;

    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [31:0] m0_adr = 0, m0_dat = 32'h1111_0000;
    logic [3:0]  m0_sel = 4'hF;
    logic [2:0]  m0_cti = 3'd0;
    logic [1:0]  m0_bte = 2'd0;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [31:0] m1_adr = 0, m1_dat = 32'h2222_0000;
    logic [3:0]  m1_sel = 4'h3;
    logic [2:0]  m1_cti = 3'd7;
    logic [1:0]  m1_bte = 2'd1;

    logic        a_s0_ack, a_s0_err, a_s0_rty, a_s1_ack, a_s1_err, a_s1_rty;
    logic [31:0] a_s0_dat_sm, a_s1_dat_sm, a_m_adr, a_m_dat_ms;
    logic        a_m_cyc, a_m_stb, a_m_we, a_m_ack, a_m_err, a_m_rty, a_force_rel;
    logic [3:0]  a_m_sel;
    logic [2:0]  a_m_cti;
    logic [1:0]  a_m_bte, a_grant;
    logic [31:0] a_m_dat_sm;

    logic        b_s0_ack, b_s0_err, b_s0_rty, b_s1_ack, b_s1_err, b_s1_rty;
    logic [31:0] b_s0_dat_sm, b_s1_dat_sm, b_m_adr, b_m_dat_ms;
    logic        b_m_cyc, b_m_stb, b_m_we, b_m_ack, b_m_err, b_m_rty, b_force_rel;
    logic [3:0]  b_m_sel;
    logic [2:0]  b_m_cti;
    logic [1:0]  b_m_bte, b_grant;
    logic [31:0] b_m_dat_sm;

    int checks = 0;
    int failures = 0;
    int a_ack0_n = 0, a_ack1_n = 0, a_fr_n = 0, b_fr_n = 0;

    always #5 clk = ~clk;

    wshb_arbiter #(.PRIO_MODE(0), .MAX_HOLD(4)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .s0_cyc(m0_cyc), .s0_stb(m0_stb), .s0_we(m0_we), .s0_adr(m0_adr), .s0_sel(m0_sel),
        .s0_dat_ms(m0_dat), .s0_cti(m0_cti), .s0_bte(m0_bte),
        .s0_ack(a_s0_ack), .s0_err(a_s0_err), .s0_rty(a_s0_rty), .s0_dat_sm(a_s0_dat_sm),
        .s1_cyc(m1_cyc), .s1_stb(m1_stb), .s1_we(m1_we), .s1_adr(m1_adr), .s1_sel(m1_sel),
        .s1_dat_ms(m1_dat), .s1_cti(m1_cti), .s1_bte(m1_bte),
        .s1_ack(a_s1_ack), .s1_err(a_s1_err), .s1_rty(a_s1_rty), .s1_dat_sm(a_s1_dat_sm),
        .m_cyc(a_m_cyc), .m_stb(a_m_stb), .m_we(a_m_we), .m_adr(a_m_adr), .m_sel(a_m_sel),
        .m_dat_ms(a_m_dat_ms), .m_cti(a_m_cti), .m_bte(a_m_bte),
        .m_ack(a_m_ack), .m_err(a_m_err), .m_rty(a_m_rty), .m_dat_sm(a_m_dat_sm),
        .grant(a_grant), .force_rel(a_force_rel)
    );

    wshb_arbiter #(.PRIO_MODE(1), .MAX_HOLD(0)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .s0_cyc(m0_cyc), .s0_stb(m0_stb), .s0_we(m0_we), .s0_adr(m0_adr), .s0_sel(m0_sel),
        .s0_dat_ms(m0_dat), .s0_cti(m0_cti), .s0_bte(m0_bte),
        .s0_ack(b_s0_ack), .s0_err(b_s0_err), .s0_rty(b_s0_rty), .s0_dat_sm(b_s0_dat_sm),
        .s1_cyc(m1_cyc), .s1_stb(m1_stb), .s1_we(m1_we), .s1_adr(m1_adr), .s1_sel(m1_sel),
        .s1_dat_ms(m1_dat), .s1_cti(m1_cti), .s1_bte(m1_bte),
        .s1_ack(b_s1_ack), .s1_err(b_s1_err), .s1_rty(b_s1_rty), .s1_dat_sm(b_s1_dat_sm),
        .m_cyc(b_m_cyc), .m_stb(b_m_stb), .m_we(b_m_we), .m_adr(b_m_adr), .m_sel(b_m_sel),
        .m_dat_ms(b_m_dat_ms), .m_cti(b_m_cti), .m_bte(b_m_bte),
        .m_ack(b_m_ack), .m_err(b_m_err), .m_rty(b_m_rty), .m_dat_sm(b_m_dat_sm),
        .grant(b_grant), .force_rel(b_force_rel)
    );

    // SDRAM stand-ins: ack every other cycle, read data = address ^ KEY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_m_ack <= 1'b0; a_m_dat_sm <= '0;
            b_m_ack <= 1'b0; b_m_dat_sm <= '0;
        end else begin
            a_m_ack <= a_m_cyc & a_m_stb & ~a_m_ack;
            a_m_dat_sm <= a_m_adr ^ KEY;
            b_m_ack <= b_m_cyc & b_m_stb & ~b_m_ack;
            b_m_dat_sm <= b_m_adr ^ KEY;
        end
    end
    assign a_m_err = err_inj & a_m_cyc;
    assign b_m_err = err_inj & b_m_cyc;
    assign a_m_rty = 1'b0;
    assign b_m_rty = 1'b0;

    always_ff @(posedge clk) begin
        a_ack0_n <= a_ack0_n + int'(a_s0_ack);
        a_ack1_n <= a_ack1_n + int'(a_s1_ack);
        a_fr_n   <= a_fr_n + int'(a_force_rel);
        b_fr_n   <= b_fr_n + int'(b_force_rel);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return a_s0_ack;
            1: return a_s1_ack;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string tag);
        bit hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (sig(sel)) hit = 1;
        end
        check_val(tag, 32'(hit), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int n0, n1, fa, fb;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_val("rst_grant_a", 32'(a_grant), 32'd0);
        check_val("rst_grant_b", 32'(b_grant), 32'd0);
        check_val("rst_cyc", 32'(a_m_cyc), 32'd0);
        check_val("rst_ack0", 32'(a_s0_ack), 32'd0);
        check_val("rst_ack1", 32'(a_s1_ack), 32'd0);

        // Tie after reset: m0 first, one idle cycle, then m1
        step();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h200;
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h300;
        @(negedge clk);
        check_val("tie_latency", 32'(a_grant), 32'd0);
        @(negedge clk);
        check_val("tie_m0_first_a", 32'(a_grant), 32'd1);
        check_val("tie_m0_first_b", 32'(b_grant), 32'd1);
        check_val("pass_adr0", a_m_adr, 32'h200);
        check_val("pass_sel0", 32'(a_m_sel), 32'hF);
        wait_for(0, "tie_m0_ack");
        step();
        m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        @(negedge clk);
        check_val("tie_idle_gap", 32'(a_grant), 32'd0);
        check_val("tie_idle_cyc", 32'(a_m_cyc), 32'd0);
        @(negedge clk);
        check_val("tie_m1_next", 32'(a_grant), 32'd2);
        check_val("pass_adr1", a_m_adr, 32'h300);
        check_val("pass_cti1", 32'(a_m_cti), 32'd7);
        wait_for(1, "tie_m1_ack");
        check_val("m1_dat_sm", a_s1_dat_sm, 32'h300 ^ KEY);
        check_val("m0_dat_sm_idle", a_s0_dat_sm, 32'd0);
        step();
        m1_cyc = 0; m1_stb = 0;
        repeat (3) @(negedge clk);

        // Master 0 alone: four single writes
        n0 = a_ack0_n; n1 = a_ack1_n;
        step();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h100;
        @(negedge clk);
        check_val("solo_latency", 32'(a_grant), 32'd0);
        @(negedge clk);
        check_val("solo_grant", 32'(a_grant), 32'd1);
        for (int i = 0; i < 4; i++) begin
            wait_for(0, "solo_ack");
            check_val("solo_adr", a_m_adr, 32'h100 + 32'(4 * i));
            check_val("solo_dat_sm", a_s0_dat_sm, (32'h100 + 32'(4 * i)) ^ KEY);
            step();
            if (i < 3) m0_adr = m0_adr + 32'd4;
        end
        m0_cyc = 0; m0_stb = 0;
        repeat (3) @(negedge clk);
        check_val("solo_ack0_count", 32'(a_ack0_n - n0), 32'd4);
        check_val("solo_ack1_quiet", 32'(a_ack1_n - n1), 32'd0);

        // Tie again: round-robin now favours m1, fixed priority still m0
        step();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h200;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300;
        @(negedge clk);
        @(negedge clk);
        check_val("rr_m1_first", 32'(a_grant), 32'd2);
        check_val("prio_m0_first", 32'(b_grant), 32'd1);

        // Fixed priority: m0 wins every re-arbitration while m1 keeps waiting
        for (int r = 0; r < 3; r++) begin
            step();
            m0_cyc = 0; m0_stb = 0;
            step();
            m0_cyc = 1; m0_stb = 1;
            @(negedge clk);
            check_val("prio_idle", 32'(b_grant), 32'd0);
            @(negedge clk);
            check_val("prio_rearb_m0", 32'(b_grant), 32'd1);
        end
        step();
        m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        @(negedge clk);
        check_val("prio_gap", 32'(b_grant), 32'd0);
        @(negedge clk);
        check_val("prio_m1_when_m0_idle", 32'(b_grant), 32'd2);
        step();
        m1_cyc = 0; m1_stb = 0;
        repeat (4) @(negedge clk);
        check_val("all_idle_a", 32'(a_grant), 32'd0);

        // Hold limit: m0 keeps the bus for 10 acks while m1 waits
        fa = a_fr_n; fb = b_fr_n;
        step();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h400;
        @(negedge clk);
        @(negedge clk);
        check_val("hold_owner", 32'(a_grant), 32'd1);
        step();
        m1_cyc = 1; m1_stb = 1;
        for (int k = 1; k <= 10; k++) begin
            wait_for(0, "hold_ack");
            if (k == 4) check_val("fr_not_early", 32'(a_fr_n - fa), 32'd0);
            if (k == 6) check_val("fr_after_4th", 32'(a_fr_n - fa), 32'd1);
        end
        check_val("hold_no_preempt", 32'(a_grant), 32'd1);
        err_inj = 1'b1;
        #1;
        check_val("err_to_owner", 32'(a_s0_err), 32'd1);
        check_val("err_not_other", 32'(a_s1_err), 32'd0);
        check_val("err_keeps_grant", 32'(a_grant), 32'd1);
        err_inj = 1'b0;
        check_val("fr_single_pulse", 32'(a_fr_n - fa), 32'd1);
        check_val("fr_unlimited_b", 32'(b_fr_n - fb), 32'd0);
        step();
        m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        @(negedge clk);
        check_val("handoff_gap", 32'(a_grant), 32'd0);
        @(negedge clk);
        check_val("handoff_m1", 32'(a_grant), 32'd2);

        // Async reset in the middle of m1's burst
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_cyc", 32'(a_m_cyc), 32'd0);
        check_val("rst_mid_stb", 32'(a_m_stb), 32'd0);
        check_val("rst_mid_grant", 32'(a_grant), 32'd0);
        m0_cyc = 1; m0_stb = 1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_m0_first", 32'(a_grant), 32'd1);
        step();
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
